// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: 720p60 defaults,
// output word layout and the back-porch legality rule.
package video_timing_pkg;

    localparam int unsigned VT_HACT   = 1280;
    localparam int unsigned VT_HFP    = 110;
    localparam int unsigned VT_HSW    = 40;
    localparam int unsigned VT_HBP    = 220;
    localparam int unsigned VT_VACT   = 720;
    localparam int unsigned VT_VFP    = 5;
    localparam int unsigned VT_VSW    = 5;
    localparam int unsigned VT_VBP    = 20;
    localparam bit          VT_HS_POL = 1'b1;
    localparam bit          VT_VS_POL = 1'b1;

    // Encoder needs this many back-porch clocks for its data island.
    localparam int unsigned VT_MIN_HBP = 72;

    localparam int unsigned DD_W       = 27;
    localparam int unsigned DD_RGB_W   = 24;
    localparam int unsigned DD_RGB_LSB = 3;
    localparam int unsigned DD_DE      = 2;
    localparam int unsigned DD_HS      = 1;
    localparam int unsigned DD_VS      = 0;

    function automatic bit hbp_fits_data_island(input int unsigned hbp);
        return hbp >= VT_MIN_HBP;
    endfunction

endpackage

// File: rtl/raster_axis_counter.sv
// One raster axis: wrapping position counter with active/sync region decode.
module raster_axis_counter #(
    parameter int unsigned ACT = 4,
    parameter int unsigned FP  = 1,
    parameter int unsigned SW  = 1,
    parameter int unsigned BP  = 1,
    parameter int unsigned W   = $clog2(ACT + FP + SW + BP)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         in_active_o,
    output logic         in_sync_o
);

    localparam int unsigned TOT = ACT + FP + SW + BP;

    logic [W-1:0] count_q, count_d;
    logic         at_last;

    assign at_last = (count_q == W'(TOT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (step_i) begin
            count_d = at_last ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign wrap_o      = step_i & at_last;
    assign in_active_o = (count_q < W'(ACT));
    assign in_sync_o   = (count_q >= W'(ACT + FP)) && (count_q < W'(ACT + FP + SW));

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pulls pixels from the source, emits the registered
// {RGB,DE,HSYNC,VSYNC} word for the HDMI encoder plus line/frame strobes.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned HACT   = VT_HACT,
    parameter int unsigned HFP    = VT_HFP,
    parameter int unsigned HSW    = VT_HSW,
    parameter int unsigned HBP    = VT_HBP,
    parameter int unsigned VACT   = VT_VACT,
    parameter int unsigned VFP    = VT_VFP,
    parameter int unsigned VSW    = VT_VSW,
    parameter int unsigned VBP    = VT_VBP,
    parameter bit          HS_POL = VT_HS_POL,
    parameter bit          VS_POL = VT_VS_POL,
    parameter bit          ENFORCE_DATA_ISLAND = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DD_RGB_W-1:0] pix,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [DD_W-1:0]     dd1,
    output logic                frame_start,
    output logic                line_start,
    output logic                underflow,
    input  logic                underflow_clr
);

    localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
    localparam int unsigned VTOT = VACT + VFP + VSW + VBP;
    localparam int unsigned HW   = $clog2(HTOT);
    localparam int unsigned VW   = $clog2(VTOT);
    localparam int unsigned HSS  = HACT + HFP;
    localparam int unsigned VSS  = VACT + VFP;
    localparam int unsigned VSE  = VACT + VFP + VSW;
    localparam logic [DD_W-1:0] IDLE_WORD = {DD_RGB_W'(0), 1'b0, ~HS_POL, ~VS_POL};

    if (ENFORCE_DATA_ISLAND && !hbp_fits_data_island(HBP)) begin : g_hbp_too_short
        $error("video_timing: HBP=%0d leaves no room for the data island", HBP);
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync_line;

    raster_axis_counter #(.ACT(HACT), .FP(HFP), .SW(HSW), .BP(HBP), .W(HW)) u_hcnt (
        .clk         (clk),
        .reset       (reset),
        .step_i      (1'b1),
        .clear_i     (~en),
        .count_o     (hcnt),
        .wrap_o      (h_wrap),
        .in_active_o (h_act),
        .in_sync_o   (h_sync)
    );

    raster_axis_counter #(.ACT(VACT), .FP(VFP), .SW(VSW), .BP(VBP), .W(VW)) u_vcnt (
        .clk         (clk),
        .reset       (reset),
        .step_i      (h_wrap),
        .clear_i     (~en),
        .count_o     (vcnt),
        .wrap_o      (v_wrap),
        .in_active_o (v_act),
        .in_sync_o   (v_sync_line)
    );

    logic              active, hsync_on, vsync_on, v_prev_sync;
    logic [DD_W-1:0]   dd1_q, dd1_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              underflow_q, underflow_d;
    logic              at_origin_q, at_origin_d;

    // VSYNC edges move with the HSYNC leading edge, so the pulse straddles line boundaries.
    assign v_prev_sync = (32'(vcnt) >= VSS + 1) && (32'(vcnt) <= VSE);
    assign active      = en & h_act & v_act;
    assign hsync_on    = en & h_sync;
    assign vsync_on    = en & ((v_sync_line & (hcnt >= HW'(HSS))) |
                               (v_prev_sync & (hcnt <  HW'(HSS))));
    assign pix_ready   = active & ~reset;

    always_comb begin
        dd1_d                             = IDLE_WORD;
        dd1_d[DD_RGB_LSB +: DD_RGB_W]     = (active && pix_valid) ? pix : DD_RGB_W'(0);
        dd1_d[DD_DE]                      = active;
        dd1_d[DD_HS]                      = hsync_on ? HS_POL : ~HS_POL;
        dd1_d[DD_VS]                      = vsync_on ? VS_POL : ~VS_POL;
        line_start_d                      = en && (hcnt == '0);
        frame_start_d                     = en && at_origin_q;
        at_origin_d                       = ~en | v_wrap;
        underflow_d                       = (active & ~pix_valid) | (underflow_q & ~underflow_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dd1_q         <= IDLE_WORD;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            at_origin_q   <= 1'b1;
        end else begin
            dd1_q         <= dd1_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            at_origin_q   <= at_origin_d;
        end
    end

    assign dd1         = dd1_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_timing.sv
// Randomised bench for video_timing: three instances (small raster at both sync
// polarities, default 720p) checked against a linear-position raster model.
module tb_video_timing;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp;
    } geo_t;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset, en, pix_valid, underflow_clr;
    logic [23:0] pix;

    logic        rdy [NI];
    logic [26:0] dd  [NI];
    logic        fs  [NI];
    logic        ls  [NI];
    logic        uf  [NI];

    geo_t geo  [NI];
    int   t    [NI];
    bit   ufm  [NI];
    bit   last_acc;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    video_timing #(.HACT(4), .HFP(1), .HSW(2), .HBP(3), .VACT(2), .VFP(1), .VSW(1), .VBP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .ENFORCE_DATA_ISLAND(1'b0)) u_small (
        .clk(clk), .reset(reset), .en(en), .pix(pix), .pix_valid(pix_valid),
        .pix_ready(rdy[0]), .dd1(dd[0]), .frame_start(fs[0]), .line_start(ls[0]),
        .underflow(uf[0]), .underflow_clr(underflow_clr));

    video_timing #(.HACT(4), .HFP(1), .HSW(2), .HBP(3), .VACT(2), .VFP(1), .VSW(1), .VBP(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .ENFORCE_DATA_ISLAND(1'b0)) u_neg (
        .clk(clk), .reset(reset), .en(en), .pix(pix), .pix_valid(pix_valid),
        .pix_ready(rdy[1]), .dd1(dd[1]), .frame_start(fs[1]), .line_start(ls[1]),
        .underflow(uf[1]), .underflow_clr(underflow_clr));

    video_timing u_720p (
        .clk(clk), .reset(reset), .en(en), .pix(pix), .pix_valid(pix_valid),
        .pix_ready(rdy[2]), .dd1(dd[2]), .frame_start(fs[2]), .line_start(ls[2]),
        .underflow(uf[2]), .underflow_clr(underflow_clr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int htot(input geo_t g);
        return g.ha + g.hf + g.hs + g.hb;
    endfunction

    function automatic int ftot(input geo_t g);
        return htot(g) * (g.va + g.vf + g.vs + g.vb);
    endfunction

    function automatic bit m_active(input geo_t g, input int tt, input bit e);
        return e && ((tt % htot(g)) < g.ha) && ((tt / htot(g)) < g.va);
    endfunction

    function automatic logic [26:0] m_idle(input geo_t g);
        return {24'h0, 1'b0, ~g.hp, ~g.vp};
    endfunction

    // VSYNC window expressed as a span of linear pixel positions.
    function automatic logic [26:0] m_word(input geo_t g, input int tt, input bit e,
                                           input logic [23:0] px, input bit pv);
        int ht;
        int h;
        int vs0;
        int vs1;
        bit act, hs_on, vs_on;
        ht  = htot(g);
        h   = tt % ht;
        vs0 = (g.va + g.vf) * ht + g.ha + g.hf;
        vs1 = vs0 + g.vs * ht;
        if (!e) return m_idle(g);
        act   = m_active(g, tt, e);
        hs_on = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
        vs_on = (tt >= vs0) && (tt < vs1);
        return {(act && pv) ? px : 24'h0, act, hs_on ? g.hp : ~g.hp, vs_on ? g.vp : ~g.vp};
    endfunction

    task automatic check_idle(input string why);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_ready%0d", why, i), 32'(rdy[i]), 32'(0));
            check($sformatf("%s_dd1_%0d", why, i), 32'(dd[i]), 32'(m_idle(geo[i])));
            check($sformatf("%s_fs%0d", why, i), 32'(fs[i]), 32'(0));
            check($sformatf("%s_ls%0d", why, i), 32'(ls[i]), 32'(0));
            check($sformatf("%s_uf%0d", why, i), 32'(uf[i]), 32'(0));
        end
    endtask

    // Drives one clock of inputs (called just after a rising edge) and checks all outputs.
    task automatic cycle(input bit e, input bit pv, input logic [23:0] px, input bit clr);
        logic [26:0] ew  [NI];
        bit          efs [NI];
        bit          els [NI];
        bit          act;
        en = e; pix_valid = pv; pix = px; underflow_clr = clr;
        #1;
        last_acc = m_active(geo[0], t[0], e) && pv;
        for (int i = 0; i < NI; i++) begin
            act = m_active(geo[i], t[i], e);
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(act));
            ew[i]  = m_word(geo[i], t[i], e, px, pv);
            els[i] = e && ((t[i] % htot(geo[i])) == 0);
            efs[i] = e && (t[i] == 0);
            ufm[i] = (act && !pv) || (ufm[i] && !clr);
            t[i]   = e ? (t[i] + 1) % ftot(geo[i]) : 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("dd1_%0d", i), 32'(dd[i]), 32'(ew[i]));
            check($sformatf("frame_start%0d", i), 32'(fs[i]), 32'(efs[i]));
            check($sformatf("line_start%0d", i), 32'(ls[i]), 32'(els[i]));
            check($sformatf("underflow%0d", i), 32'(uf[i]), 32'(ufm[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            t[i]   = 0;
            ufm[i] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] px;
        int          hs_cnt, exp_rgb, bound;
        int          prev_ls, prev_fs, de_n, hs_n;

        geo[0] = '{ha:4, hf:1, hs:2, hb:3, va:2, vf:1, vs:1, vb:1, hp:1'b1, vp:1'b1};
        geo[1] = '{ha:4, hf:1, hs:2, hb:3, va:2, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0};
        geo[2] = '{ha:1280, hf:110, hs:40, hb:220, va:720, vf:5, vs:5, vb:20, hp:1'b1, vp:1'b1};

        reset = 1'b1; en = 1'b1; pix_valid = 1'b0; pix = '0; underflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        model_reset();

        // Counting source, always valid: RGB follows 1,2,3... across active pixels.
        px = 24'd1; hs_cnt = 0; exp_rgb = 1;
        for (int c = 0; c < 100; c++) begin
            cycle(1'b1, 1'b1, px, 1'b0);
            if (dd[0][2]) begin
                check("rgb_seq", 32'(dd[0][26:3]), 32'(exp_rgb));
                exp_rgb++;
            end
            if (last_acc) begin
                px = px + 24'd1;
                hs_cnt++;
            end
            if (c == 49 || c == 99) begin
                check("handshakes_per_frame", 32'(hs_cnt), 32'd8);
                hs_cnt = 0;
            end
        end

        // Starve active pixel 2 of line 0, then exercise clear and set-wins-over-clear.
        cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 24'hABCDEF, 1'b0);
        check("underflow_black_de", 32'(dd[0][26:2]), 32'h1);
        check("underflow_set", 32'(uf[0]), 32'd1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
        check("underflow_sticky", 32'(uf[0]), 32'd1);
        cycle(1'b1, 1'b1, 24'($urandom), 1'b1);
        check("underflow_cleared", 32'(uf[0]), 32'd0);
        bound = 0;
        while (!m_active(geo[0], t[0], 1'b1) && bound < 60) begin
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
            bound++;
        end
        cycle(1'b1, 1'b0, 24'($urandom), 1'b1);
        check("underflow_set_wins", 32'(uf[0]), 32'd1);

        // Random traffic with an enable gap of 7 clocks in the middle.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                for (int k = 0; k < 7; k++) begin
                    cycle(1'b0, 1'b1, 24'($urandom), 1'b0);
                    check("en_low_idle_neg", 32'(dd[1][2:0]), 32'h3);
                end
                cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
                check("en_restart_fs", 32'(fs[1]), 32'd1);
            end
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0,
                  24'($urandom), $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of an active line (line 1, pixel 2).
        bound = 0;
        while (t[0] != 12 && bound < 60) begin
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
            bound++;
        end
        check("reach_mid_line", 32'(t[0]), 32'd12);
        en = 1'b1; pix_valid = 1'b1; reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midreset_ready%0d", i), 32'(rdy[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        check_idle("midreset");
        reset = 1'b0;
        model_reset();

        // Long run from origin: measure 720p line period, DE and HSYNC widths.
        prev_ls = -1; prev_fs = -1; de_n = 0; hs_n = 0;
        for (int c = 0; c < 3400; c++) begin
            cycle(1'b1, $urandom_range(0, 9) != 0, 24'($urandom), $urandom_range(0, 15) == 0);
            if (c == 0) check("restart_fs_small", 32'(fs[0]), 32'd1);
            if (ls[2]) begin
                if (prev_ls >= 0) begin
                    check("htot_720p", 32'(c - prev_ls), 32'd1650);
                    check("de_per_line_720p", 32'(de_n), 32'd1280);
                    check("hsync_width_720p", 32'(hs_n), 32'd40);
                end
                prev_ls = c; de_n = 0; hs_n = 0;
            end
            if (dd[2][2]) de_n++;
            if (dd[2][1]) hs_n++;
            if (fs[0]) begin
                if (prev_fs >= 0) check("frame_period_small", 32'(c - prev_fs), 32'd50);
                prev_fs = c;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
